uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one `Uart_protocol` transmitter between up to eight byte requesters. It sits between the requesters and the transmitter's `data_in`/`send`/`tx_busy` interface. It grants one requester at a time, issues a single-cycle `send` strobe, and tracks `tx_busy` through the whole frame before it arbitrates again.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter_if                                           |
// | Description : Requester and transmitter handshake bundle for the arbiter.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           data_in;
    logic                 send;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;
    logic                 arb_busy;
    logic                 timeout_err;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, data_in, send, grant_id, arb_busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, data_in, send, grant_id, arb_busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin arbiter sharing one UART transmitter among up to  |
// |               eight byte requesters. Optional watchdog: UART_ARB_TIMEOUT_EN|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("uart_tx_arbiter: illegal parameter values");
        end
    endgenerate

    state_t               r_state;
    logic                 r_send;
    logic [NUM_REQ-1:0]   r_ready;
    logic [7:0]           r_data;
    logic [ID_W-1:0]      r_grant;
    logic [ID_W-1:0]      r_last;
    logic                 r_busy;

    logic [7:0]           w_bytes [NUM_REQ];
    logic [ID_W-1:0]      w_idx;
    logic [ID_W-1:0]      w_winner;
    logic [7:0]           w_byte;
    logic                 w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign w_bytes[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    // Search downward from last+NUM_REQ so the closest index after last is the final hit.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_byte   = 8'h00;
        w_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            if (bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
                w_byte   = w_bytes[w_idx];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_terr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_send  <= 1'b0;
            r_ready <= '0;
            r_data  <= 8'h00;
            r_grant <= '0;
            r_last  <= ID_W'(NUM_REQ - 1);
            r_busy  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_terr  <= 1'b0;
`endif
        end else begin
            r_send  <= 1'b0;
            r_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_terr  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!bus.tx_busy && w_found) begin
                        r_data  <= w_byte;
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_send  <= 1'b1;
                        r_ready <= NUM_REQ'(1) << w_winner;
                        r_busy  <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_terr  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.send      = r_send;
    assign bus.req_ready = r_ready;
    assign bus.data_in   = r_data;
    assign bus.grant_id  = r_grant;
    assign bus.arb_busy  = r_busy;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_err = r_terr;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire
